// File: rtl/wb_data_ram_slave_pkg.sv
// -----------------------------------------------------------------------------
// wb_data_ram_slave_pkg
// Shared definitions for the Wishbone data-RAM slave:
//   - WB data and byte-select widths
//   - default user-window base address and decode mask
//   - slave FSM state encoding
//   - window_hit() helper used by the address decoder
// No ports (package).
// -----------------------------------------------------------------------------
package wb_data_ram_slave_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  localparam logic [31:0] USER_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] USER_ADDR_MASK = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } wb_ram_state_e;

  // A byte address belongs to the window when its masked bits equal the base.
  function automatic logic window_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_data_ram_slave_if.sv
// -----------------------------------------------------------------------------
// wb_data_ram_slave_if
// Wishbone classic slave-side bus bundle (signal names as seen by the slave).
//   wbs_cyc_i  cycle          wbs_stb_i  strobe        wbs_we_i  1 = write
//   wbs_sel_i  byte lanes     wbs_adr_i  byte address  wbs_dat_i write data
//   wbs_ack_o  acknowledge    wbs_dat_o  read data
// Modports: master drives the request side, slave drives ack and read data.
// -----------------------------------------------------------------------------
interface wb_data_ram_slave_if;
  import wb_data_ram_slave_pkg::*;

  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [WB_SW-1:0] wbs_sel_i;
  logic [31:0]      wbs_adr_i;
  logic [WB_DW-1:0] wbs_dat_i;
  logic             wbs_ack_o;
  logic [WB_DW-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_data_ram_slave.sv
// -----------------------------------------------------------------------------
// wb_data_ram_slave
// Wishbone classic slave that fronts a single-port OpenRAM-style data SRAM.
// Each WB access becomes one SRAM strobe; ack and read data are registered.
// Ports:
//   wb_clk_i      clock shared by the bus and the SRAM
//   wb_rst_i      synchronous active-high reset
//   wbs           Wishbone slave bundle (wb_data_ram_slave_if.slave)
//   ram_csb0_o    SRAM chip select, active-low
//   ram_web0_o    SRAM write enable, active-low
//   ram_wmask0_o  SRAM byte write mask
//   ram_addr0_o   SRAM word address (byte address bits [AW+1:2])
//   ram_din0_o    SRAM write data
//   ram_dout0_i   SRAM read data
// -----------------------------------------------------------------------------
module wb_data_ram_slave
  import wb_data_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = USER_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = USER_ADDR_MASK,
  parameter int          AW        = 8,
  parameter int          READ_LAT  = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_data_ram_slave_if.slave wbs,
  output logic              ram_csb0_o,
  output logic              ram_web0_o,
  output logic [WB_SW-1:0]  ram_wmask0_o,
  output logic [AW-1:0]     ram_addr0_o,
  output logic [WB_DW-1:0]  ram_din0_o,
  input  logic [WB_DW-1:0]  ram_dout0_i
);

  // Number of WAIT cycles minus one; the counter runs down to zero.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

  wb_ram_state_e    state;
  logic             we_q;
  logic [1:0]       wait_cnt;
  logic             ack_q;
  logic [WB_DW-1:0] dat_q;
  logic             request;

  // A request is only acted on in IDLE; a miss is simply ignored.
  assign request = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                   window_hit(wbs.wbs_adr_i, BASE_ADDR, ADDR_MASK);

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // Slave FSM with all bus and SRAM outputs registered.
  // IDLE latches the request and strobes the SRAM for exactly one cycle
  // (ACCESS). Writes acknowledge right after the strobe; reads wait
  // READ_LAT cycles and capture the SRAM output on the last one. Dropping
  // cyc during ACCESS/WAIT lets the SRAM strobe stand but suppresses ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      we_q         <= 1'b0;
      wait_cnt     <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      ram_csb0_o   <= 1'b1;
      ram_web0_o   <= 1'b1;
      ram_wmask0_o <= '0;
      ram_addr0_o  <= '0;
      ram_din0_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_q <= 1'b0;
          dat_q <= '0;
          if (request) begin
            state        <= ST_ACCESS;
            we_q         <= wbs.wbs_we_i;
            ram_csb0_o   <= 1'b0;
            ram_web0_o   <= ~wbs.wbs_we_i;
            ram_wmask0_o <= wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
            ram_addr0_o  <= wbs.wbs_adr_i[AW+1:2];
            ram_din0_o   <= wbs.wbs_dat_i;
          end
        end

        ST_ACCESS: begin
          ram_csb0_o   <= 1'b1;
          ram_web0_o   <= 1'b1;
          ram_wmask0_o <= '0;
          if (!wbs.wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (we_q) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
            dat_q <= '0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end

        ST_WAIT: begin
          if (!wbs.wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 2'd0) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
            dat_q <= ram_dout0_i;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        ST_ACK: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
          dat_q <= '0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_data_ram_slave
// Directed bench for wb_data_ram_slave with a behavioural 256x32 SRAM
// (one-cycle read latency, byte-masked writes) attached to the SRAM port.
// -----------------------------------------------------------------------------
module tb_wb_data_ram_slave;
  import wb_data_ram_slave_pkg::*;

  localparam int AW = 8;

  logic clock = 1'b0;
  logic reset;

  // 100 MHz bus clock.
  always #5 clock = ~clock;

  wb_data_ram_slave_if bus();

  logic          ramCsb;
  logic          ramWeb;
  logic [3:0]    ramWmask;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramDin;
  logic [31:0]   ramDout;

  wb_data_ram_slave #(
    .BASE_ADDR (32'h3000_0000),
    .ADDR_MASK (32'hFFFF_FC00),
    .AW        (AW),
    .READ_LAT  (1)
  ) dut (
    .wb_clk_i     (clock),
    .wb_rst_i     (reset),
    .wbs          (bus.slave),
    .ram_csb0_o   (ramCsb),
    .ram_web0_o   (ramWeb),
    .ram_wmask0_o (ramWmask),
    .ram_addr0_o  (ramAddr),
    .ram_din0_o   (ramDin),
    .ram_dout0_i  (ramDout)
  );

  // Behavioural SRAM: strobes sampled on the rising edge, read data one cycle later.
  logic [31:0] mem [0:255];
  always @(posedge clock) begin
    if (!ramCsb) begin
      if (!ramWeb) begin
        for (int b = 0; b < 4; b++) begin
          if (ramWmask[b]) mem[ramAddr][8*b +: 8] <= ramDin[8*b +: 8];
        end
      end else begin
        ramDout <= mem[ramAddr];
      end
    end
  end

  int checkCount = 0;
  int passCount  = 0;

  // Snapshot of the SRAM strobes one cycle after the request, and leak counter.
  logic          t1Csb;
  logic          t1Web;
  logic [3:0]    t1Wmask;
  logic [AW-1:0] t1Addr;
  logic          ackAfter;
  int            datLeak;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive the master side of the bus.
  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel);
    bus.wbs_cyc_i = cyc;
    bus.wbs_stb_i = stb;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  // Full handshake: hold the request until ack (bounded), then release.
  // lat is the number of clock edges from request to ack, -1 on timeout.
  task automatic wbAccess(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output logic [31:0] rdata, output int lat);
    applyStimulus(1'b1, 1'b1, we, adr, dat, sel);
    lat     = -1;
    rdata   = '0;
    datLeak = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (i == 1) begin
        t1Csb   = ramCsb;
        t1Web   = ramWeb;
        t1Wmask = ramWmask;
        t1Addr  = ramAddr;
      end
      if (!bus.wbs_ack_o && bus.wbs_dat_o != 32'h0) datLeak++;
      if (bus.wbs_ack_o) begin
        lat   = i;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clock); #1;
    ackAfter = bus.wbs_ack_o;
  endtask

  logic [31:0] rdata;
  int          lat;
  int          ackSeen;
  int          csbSeen;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ack",   32'(bus.wbs_ack_o), 32'h0);
    checkOutput("reset_dat",   bus.wbs_dat_o,      32'h0);
    checkOutput("reset_csb",   32'(ramCsb),        32'h1);
    checkOutput("reset_web",   32'(ramWeb),        32'h1);
    checkOutput("reset_wmask", 32'(ramWmask),      32'h0);
    checkOutput("reset_addr",  32'(ramAddr),       32'h0);
    checkOutput("reset_din",   ramDin,             32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: full-word write then read back at word 0.
    wbAccess(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, rdata, lat);
    checkOutput("t1_wr_csb",   32'(t1Csb),   32'h0);
    checkOutput("t1_wr_web",   32'(t1Web),   32'h0);
    checkOutput("t1_wr_wmask", 32'(t1Wmask), 32'hF);
    checkOutput("t1_wr_lat",   32'(lat),     32'd2);
    checkOutput("t1_wr_ack1",  32'(ackAfter), 32'h0);
    checkOutput("t1_wr_dat",   rdata,        32'h0);
    wbAccess(1'b0, 32'h3000_0000, 32'h0, 4'hF, rdata, lat);
    checkOutput("t1_rd_web",   32'(t1Web),   32'h1);
    checkOutput("t1_rd_wmask", 32'(t1Wmask), 32'h0);
    checkOutput("t1_rd_lat",   32'(lat),     32'd3);
    checkOutput("t1_rd_data",  rdata,        32'hDEAD_BEEF);

    // 2: byte-lane merge at word 4; read ignores its sel.
    wbAccess(1'b1, 32'h3000_0010, 32'h1122_3344, 4'hF, rdata, lat);
    checkOutput("t2_wr1_lat",  32'(lat), 32'd2);
    wbAccess(1'b1, 32'h3000_0010, 32'h00AA_0000, 4'b0100, rdata, lat);
    checkOutput("t2_wr2_wmask", 32'(t1Wmask), 32'h4);
    wbAccess(1'b0, 32'h3000_0010, 32'h0, 4'h1, rdata, lat);
    checkOutput("t2_rd_data",  rdata, 32'h11AA_3344);

    // 3: miss just above the window, request held for 16 cycles.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF);
    ackSeen = 0;
    csbSeen = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (bus.wbs_ack_o) ackSeen++;
      if (!ramCsb) csbSeen++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t3_miss_ack", 32'(ackSeen), 32'd0);
    checkOutput("t3_miss_csb", 32'(csbSeen), 32'd0);
    @(posedge clock); #1;

    // 4: top word of the window.
    wbAccess(1'b1, 32'h3000_03FC, 32'hCAFE_0001, 4'hF, rdata, lat);
    checkOutput("t4_wr_addr", 32'(t1Addr), 32'hFF);
    wbAccess(1'b0, 32'h3000_03FC, 32'h0, 4'hF, rdata, lat);
    checkOutput("t4_rd_data", rdata,         32'hCAFE_0001);
    checkOutput("t4_dat_leak", 32'(datLeak), 32'd0);

    // 5: abort a read during WAIT, then a normal write/read pair.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(posedge clock); #1;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ackSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.wbs_ack_o) ackSeen++;
    end
    checkOutput("t5_abort_ack", 32'(ackSeen), 32'd0);
    wbAccess(1'b1, 32'h3000_0020, 32'h5566_7788, 4'hF, rdata, lat);
    checkOutput("t5_wr_lat",  32'(lat), 32'd2);
    wbAccess(1'b0, 32'h3000_0020, 32'h0, 4'hF, rdata, lat);
    checkOutput("t5_rd_lat",  32'(lat), 32'd3);
    checkOutput("t5_rd_data", rdata,    32'h5566_7788);

    // 6: reset in the ACCESS cycle of a write.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0030, 32'h0000_0099, 4'hF);
    @(posedge clock); #1;
    checkOutput("t6_access_csb", 32'(ramCsb), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    checkOutput("t6_rst_csb", 32'(ramCsb),        32'h1);
    checkOutput("t6_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    checkOutput("t6_rst_dat", bus.wbs_dat_o,      32'h0);
    ackSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.wbs_ack_o) ackSeen++;
    end
    checkOutput("t6_no_ack", 32'(ackSeen), 32'd0);
    wbAccess(1'b0, 32'h3000_0000, 32'h0, 4'hF, rdata, lat);
    checkOutput("t6_rd_data", rdata, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
